cla_seq_adder: RTL and testbench

Sequencer that performs a WIDTH-bit addition by reusing one 4-bit carry-lookahead slice over WIDTH/4 cycles, least significant nibble first.
- The slice is instantiated internally.
- Carry is chained through a registered carry flop.
- Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake.
- Used where area matters more than latency: one slice is shared in time instead of a full-width adder.

---
 rtl/cla_seq_adder.sv | 196 +++++++++++++++++++
 tb/tb_cla_seq_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//
// Time-multiplexed WIDTH-bit adder. A single 4-bit carry-lookahead slice is
// reused for WIDTH/4 consecutive cycles, least significant nibble first, with
// the inter-nibble carry held in a flop between passes. Operands arrive on a
// valid/ready handshake and the result leaves on a second valid/ready
// handshake; the block handles one operation at a time.
//
// Optional feature macro: CLA_SEQ_SUB_EN
//   defined   : op_sub=1 at acceptance computes a-b (B inverted, carry-in 1,
//               cin ignored); cout=1 then means "no borrow".
//   undefined : op_sub is ignored and the block always computes a+b+cin.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand strobe
//   in_ready   operands accepted this cycle if in_valid (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   op_sub     subtract request (only with CLA_SEQ_SUB_EN)
//   out_valid  result available (DONE state)
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow of the (possibly inverted-B) addition
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead slice, purely combinational.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Every carry is expanded directly from ci, so no carry waits on another.
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];
endmodule

module cla_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state;
   state_t state_nxt;

   // Operands and result are held nibble-wise so the slice is fed by index.
   logic [NSLICE-1:0][3:0] a_q;
   logic [NSLICE-1:0][3:0] b_q;
   logic [NSLICE-1:0][3:0] sum_q;
   logic                   carry_q;
   logic                   cout_q;
   logic                   ovf_q;
   logic [IW-1:0]          idx;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             accept;
   logic             last;
   logic [3:0]       s_nib;
   logic             s_co;

`ifdef CLA_SEQ_SUB_EN
   // Subtraction is a + ~b + 1; the incoming cin is not used in that case.
   assign b_load = op_sub ? ~b   : b;
   assign c_load = op_sub ? 1'b1 : cin;
`else
   logic unused_op_sub;
   assign unused_op_sub = op_sub;
   assign b_load = b;
   assign c_load = cin;
`endif

   assign accept = in_valid & in_ready;
   assign last   = (idx == IW'(NSLICE - 1));

   cla4 u_slice (
      .a  (a_q[idx]),
      .b  (b_q[idx]),
      .ci (carry_q),
      .s  (s_nib),
      .co (s_co)
   );

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values, independent of the order the blocks are evaluated.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_nxt
      // unassigned and infers a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // ---------------- Operand registers ----------------
   // NOTE: operand latches carry no reset; they are loaded on every accept
   // and read only in RUN, so their power-up contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= a;
         b_q <= b_load;
      end
   end

   // ---------------- Slice sequencing and result ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sum_q   <= '0;
                  carry_q <= c_load;
                  idx     <= '0;
               end
            end
            RUN: begin
               sum_q[idx] <= s_nib;
               carry_q    <= s_co;
               idx        <= idx + 1'b1;
               if (last) begin
                  cout_q <= s_co;
                  // a^b^s at the MSB recovers the carry into the MSB; it
                  // differing from the carry out is signed overflow.
                  ovf_q  <= a_q[NSLICE-1][3] ^ b_q[NSLICE-1][3]
                          ^ s_nib[3] ^ s_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder
//
// Directed bench for cla_seq_adder at WIDTH=16: reset values, plain adds,
// carry ripple, signed overflow, output backpressure, reset mid-operation,
// back-to-back operations and the op_sub behaviour (subtract with
// CLA_SEQ_SUB_EN defined, ignored otherwise).
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        op_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Presents one operation while the DUT is idle, scrambles the operand
   // inputs right after acceptance, and waits (bounded) for out_valid.
   // lat = edges from acceptance to out_valid; rdy_seen = in_ready seen high.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic tsub,
                        output int lat, output bit rdy_seen);
      a = ta; b = tb; cin = tc; op_sub = tsub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta; b = ~tb; cin = ~tc; op_sub = ~tsub;
      lat = 0;
      rdy_seen = in_ready;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (in_ready) rdy_seen = 1'b1;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; op_sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_add();
      int lat; bit rdy;
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, rdy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy: got %b expected 0", rdy); end
      checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL basic_sum: got %h expected 5555", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", cout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
      release_result();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after: got %b expected 0", out_valid); end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] va [2] = '{16'hFFFF, 16'hFFFF};
      logic [15:0] vb [2] = '{16'h0001, 16'h0000};
      logic        vc [2] = '{1'b0, 1'b1};
      int lat; bit rdy;
      for (int i = 0; i < 2; i++) begin
         do_op(va[i], vb[i], vc[i], 1'b0, lat, rdy);
         checks++; if (lat !== 4) begin errors++; $display("FAIL ripple%0d_latency: got %0d expected 4", i, lat); end
         checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL ripple%0d_sum: got %h expected 0000", i, sum); end
         checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple%0d_cout: got %b expected 1", i, cout); end
         checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ripple%0d_ovf: got %b expected 0", i, ovf); end
         release_result();
      end
   endtask

   task automatic test_overflow();
      logic [15:0] va [2] = '{16'h7FFF, 16'h8000};
      logic [15:0] vb [2] = '{16'h0001, 16'h8000};
      logic [15:0] vs [2] = '{16'h8000, 16'h0000};
      logic        vco[2] = '{1'b0, 1'b1};
      int lat; bit rdy;
      for (int i = 0; i < 2; i++) begin
         do_op(va[i], vb[i], 1'b0, 1'b0, lat, rdy);
         checks++; if (sum !== vs[i]) begin errors++; $display("FAIL ovf%0d_sum: got %h expected %h", i, sum, vs[i]); end
         checks++; if (cout !== vco[i]) begin errors++; $display("FAIL ovf%0d_cout: got %b expected %b", i, cout, vco[i]); end
         checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf%0d_ovf: got %b expected 1", i, ovf); end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int lat; bit rdy;
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, rdy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
      for (int i = 0; i < 5; i++) begin
         // in_valid pulses with fresh operands must be ignored while busy.
         in_valid = (i % 2 == 0); a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid: got %b expected 1", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready: got %b expected 0", i, in_ready); end
         checks++; if (sum !== 16'h2345) begin errors++; $display("FAIL bp%0d_sum: got %h expected 2345", i, sum); end
         checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL bp%0d_flags: got cout=%b ovf=%b expected 0 0", i, cout, ovf); end
      end
      // in_valid and out_ready together in DONE: only the output side completes.
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got in_ready=%b expected 1", in_ready); end
   endtask

   task automatic test_reset_in_run();
      int lat; bit rdy; bit spurious;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;          // accepted; first RUN cycle
      in_valid = 1'b0;
      @(posedge clk); #1;          // nibble 0 written; second RUN cycle
      checks++; if (sum !== 16'h0003) begin errors++; $display("FAIL rr_partial_sum: got %h expected 0003", sum); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_out_valid: got %b expected 0", out_valid); end
      checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL rr_sum: got %h expected 0000", sum); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready: got %b expected 1", in_ready); end
      spurious = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) spurious = 1'b1;
      end
      checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL rr_no_result: got out_valid pulse expected none"); end
      do_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat, rdy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rr_new_latency: got %0d expected 4", lat); end
      checks++; if (sum !== 16'h0007) begin errors++; $display("FAIL rr_new_sum: got %h expected 0007", sum); end
      release_result();
   endtask

   task automatic test_back_to_back();
      int lat; bit rdy;
      do_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, lat, rdy);
      checks++; if (sum !== 16'h1001) begin errors++; $display("FAIL b2b0_sum: got %h expected 1001", sum); end
      release_result();
      do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, lat, rdy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL b2b1_latency: got %0d expected 4", lat); end
      checks++; if (sum !== 16'hBCDE) begin errors++; $display("FAIL b2b1_sum: got %h expected bcde", sum); end
      release_result();
   endtask

   task automatic test_op_sub();
      int lat; bit rdy;
`ifdef CLA_SEQ_SUB_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, rdy);
      checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub0_sum: got %h expected fffe", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub0_cout: got %b expected 0", cout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub0_ovf: got %b expected 0", ovf); end
      release_result();
      do_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, rdy);
      checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL sub1_sum: got %h expected 0002", sum); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub1_cout: got %b expected 1", cout); end
      release_result();
`else
      // Without the feature op_sub has no effect: 5 + 7 + 0.
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, rdy);
      checks++; if (sum !== 16'h000C) begin errors++; $display("FAIL nosub_sum: got %h expected 000c", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL nosub_cout: got %b expected 0", cout); end
      release_result();
`endif
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_carry_ripple();
      test_overflow();
      test_backpressure();
      test_reset_in_run();
      test_back_to_back();
      test_op_sub();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
